// File: rtl/capture_ctrl_if.sv
// Sample-memory port and readout valid/ready port of the capture controller.
// The master side is the capture controller; the slave side is memory plus transmitter.
interface capture_ctrl_if #(
    parameter int DEPTH_LOG2 = 10,
    parameter int DW         = 32
);
    logic [DEPTH_LOG2-1:0] mem_addr_o;
    logic                  mem_we_o;
    logic [DW-1:0]         mem_din_o;
    logic [DW-1:0]         mem_dout_i;
    logic                  rd_valid_o;
    logic [DW-1:0]         rd_data_o;
    logic                  rd_ready_i;

    modport master (
        output mem_addr_o, mem_we_o, mem_din_o, rd_valid_o, rd_data_o,
        input  mem_dout_i, rd_ready_i
    );

    modport slave (
        input  mem_addr_o, mem_we_o, mem_din_o, rd_valid_o, rd_data_o,
        output mem_dout_i, rd_ready_i
    );
endinterface

// File: rtl/capture_ctrl.sv
// Capture controller: pre-trigger ring buffer, post-trigger delay capture and
// newest-first readout of the stored samples over a valid/ready port.
module capture_ctrl #(
    parameter int DEPTH_LOG2 = 10,
    parameter int DW         = 32
) (
    input  logic              clk_i,
    input  logic              rst_in,
    input  logic [31:0]       cmd_i,
    input  logic              set_cnt_i,
    input  logic              arm_i,
    input  logic              stb_i,
    input  logic [DW-1:0]     smpls_i,
    input  logic              run_i,
    output logic              idle_o,
    capture_ctrl_if.master    bus
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_DELAY   = 3'd2,
        ST_RD_ADDR = 3'd3,
        ST_RD_WAIT = 3'd4,
        ST_RD_CAP  = 3'd5,
        ST_RD_HOLD = 3'd6
    } state_t;

    localparam logic [18:0]           DEPTH_W = 19'd1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1'b1);

    function automatic logic [18:0] calc_n_del(input logic [15:0] c);
        return ({3'b000, c} + 19'd1) << 2;
    endfunction

    function automatic logic [18:0] calc_n_rd(input logic [15:0] c);
        logic [18:0] n;
        n = calc_n_del(c);
        return (n > DEPTH_W) ? DEPTH_W : n;
    endfunction

    state_t                state_r, state_s;
    logic [DEPTH_LOG2-1:0] wr_ptr_r, wr_ptr_s;
    logic [DEPTH_LOG2-1:0] rd_ptr_r, rd_ptr_s;
    logic [15:0]           cmd_del_r, cmd_del_s;
    logic [15:0]           cmd_rd_r, cmd_rd_s;
    logic [18:0]           n_del_r, n_del_s;
    logic [18:0]           n_rd_r, n_rd_s;
    logic [18:0]           cnt_r, cnt_s;
    logic [DEPTH_LOG2-1:0] mem_addr_r, mem_addr_s;
    logic                  mem_we_r, mem_we_s;
    logic [DW-1:0]         mem_din_r, mem_din_s;
    logic                  rd_valid_r, rd_valid_s;
    logic [DW-1:0]         rd_data_r, rd_data_s;
    logic                  idle_r, idle_s;
    logic                  wr_en_s;

    // Next-state and next-register values for the whole controller.
    always_comb begin
        state_s    = state_r;
        wr_ptr_s   = wr_ptr_r;
        rd_ptr_s   = rd_ptr_r;
        n_del_s    = n_del_r;
        n_rd_s     = n_rd_r;
        cnt_s      = cnt_r;
        mem_addr_s = mem_addr_r;
        mem_din_s  = mem_din_r;
        rd_valid_s = rd_valid_r;
        rd_data_s  = rd_data_r;

        if (set_cnt_i) begin
            cmd_del_s = cmd_i[31:16];
            cmd_rd_s  = cmd_i[15:0];
        end else begin
            cmd_del_s = cmd_del_r;
            cmd_rd_s  = cmd_rd_r;
        end

        // Strobed samples are stored only while waiting for or following the trigger.
        wr_en_s  = stb_i & ((state_r == ST_ARMED) | (state_r == ST_DELAY));
        mem_we_s = wr_en_s;
        if (wr_en_s) begin
            mem_addr_s = wr_ptr_r;
            mem_din_s  = smpls_i;
            wr_ptr_s   = wr_ptr_r + PTR_ONE;
        end else begin
            mem_din_s  = mem_din_r;
        end

        case (state_r)
            ST_IDLE: begin
                if (arm_i) begin
                    state_s = ST_ARMED;
                    n_del_s = calc_n_del(cmd_del_r);
                    n_rd_s  = calc_n_rd(cmd_rd_r);
                    cnt_s   = 19'd0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ARMED: begin
                if (run_i) begin
                    state_s = ST_DELAY;
                    cnt_s   = stb_i ? 19'd1 : 19'd0;
                end else begin
                    state_s = ST_ARMED;
                end
            end
            ST_DELAY: begin
                if (stb_i && (cnt_r + 19'd1 == n_del_r)) begin
                    state_s  = ST_RD_ADDR;
                    rd_ptr_s = wr_ptr_r;
                    cnt_s    = 19'd0;
                end else if (stb_i) begin
                    cnt_s    = cnt_r + 19'd1;
                end else begin
                    state_s  = ST_DELAY;
                end
            end
            ST_RD_ADDR: begin
                mem_addr_s = rd_ptr_r;
                state_s    = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                state_s = ST_RD_CAP;
            end
            ST_RD_CAP: begin
                rd_data_s  = bus.mem_dout_i;
                rd_valid_s = 1'b1;
                state_s    = ST_RD_HOLD;
            end
            ST_RD_HOLD: begin
                // The next address is issued on the accepting edge to keep a 3-cycle word rate.
                if (bus.rd_ready_i && (cnt_r + 19'd1 == n_rd_r)) begin
                    rd_valid_s = 1'b0;
                    state_s    = ST_IDLE;
                end else if (bus.rd_ready_i) begin
                    rd_valid_s = 1'b0;
                    cnt_s      = cnt_r + 19'd1;
                    rd_ptr_s   = rd_ptr_r - PTR_ONE;
                    mem_addr_s = rd_ptr_r - PTR_ONE;
                    state_s    = ST_RD_WAIT;
                end else begin
                    state_s    = ST_RD_HOLD;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        idle_s = (state_s == ST_IDLE);
    end

    // Controller registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_in) begin
            state_r    <= ST_IDLE;
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            cmd_del_r  <= 16'd0;
            cmd_rd_r   <= 16'd0;
            n_del_r    <= 19'd0;
            n_rd_r     <= 19'd0;
            cnt_r      <= 19'd0;
            mem_addr_r <= '0;
            mem_we_r   <= 1'b0;
            mem_din_r  <= '0;
            rd_valid_r <= 1'b0;
            rd_data_r  <= '0;
            idle_r     <= 1'b1;
        end else begin
            state_r    <= state_s;
            wr_ptr_r   <= wr_ptr_s;
            rd_ptr_r   <= rd_ptr_s;
            cmd_del_r  <= cmd_del_s;
            cmd_rd_r   <= cmd_rd_s;
            n_del_r    <= n_del_s;
            n_rd_r     <= n_rd_s;
            cnt_r      <= cnt_s;
            mem_addr_r <= mem_addr_s;
            mem_we_r   <= mem_we_s;
            mem_din_r  <= mem_din_s;
            rd_valid_r <= rd_valid_s;
            rd_data_r  <= rd_data_s;
            idle_r     <= idle_s;
        end
    end

    assign bus.mem_addr_o = mem_addr_r;
    assign bus.mem_we_o   = mem_we_r;
    assign bus.mem_din_o  = mem_din_r;
    assign bus.rd_valid_o = rd_valid_r;
    assign bus.rd_data_o  = rd_data_r;
    assign idle_o         = idle_r;

endmodule
